io_input_ctrl: RTL and testbench

- Input-peripheral front end that sits directly upstream of the CPU I/O interface.
- Conditions raw board inputs: a push button and a bank of slide switches.
- On each debounced button press, latches the switch word and presents it as data_input with an is_ready_1 flag.
- The flag holds until the CPU acknowledges through its control register. Lost presses are flagged.

---
 rtl/io_pkg.sv | 19 +
 rtl/io_debounce.sv | 83 ++++++++
 rtl/io_input_ctrl.sv | 87 ++++++++
 tb/tb_io_input_ctrl.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/io_pkg.sv
// rtl/io_pkg.sv - shared types and constants for the input-peripheral front end
package io_pkg;

  typedef enum logic [1:0] {
    STABLE_LO,
    WAIT_HI,
    STABLE_HI,
    WAIT_LO
  } db_state_e;

  typedef enum logic {
    IDLE,
    FULL
  } cap_state_e;

  localparam int IO_DATA_W     = 32;
  localparam int DB_CYCLES_DEF = 1000000;

endpackage

// File: rtl/io_debounce.sv
// rtl/io_debounce.sv - 2-flop synchronizer plus debounce FSM for one raw input
// level flips after DB_CYCLES consecutive differing synchronized samples; rise is its one-cycle rising edge
module io_debounce
  import io_pkg::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_DEF,
  parameter int CNT_W     = $clog2(DB_CYCLES + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic rise
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  logic [1:0]       sync_q;
  logic             btn_s;
  db_state_e        state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             level_q;
  logic             level_dly_q;

  assign btn_s = sync_q[1];

  // The flip happens on the edge that sees the DB_CYCLES-th differing sample,
  // so the counter only has to reach DB_CYCLES-1 and can never wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q      <= 2'b00;
      state_q     <= STABLE_LO;
      cnt_q       <= '0;
      level_q     <= 1'b0;
      level_dly_q <= 1'b0;
    end else begin
      sync_q      <= {sync_q[0], raw};
      level_dly_q <= level_q;
      case (state_q)
        STABLE_LO: if (btn_s) begin
          state_q <= WAIT_HI;
          cnt_q   <= CNT_W'(1);
        end
        STABLE_HI: if (!btn_s) begin
          state_q <= WAIT_LO;
          cnt_q   <= CNT_W'(1);
        end
        WAIT_HI: begin
          if (!btn_s) begin
            state_q <= STABLE_LO;
            cnt_q   <= '0;
          end else if (cnt_q == CNT_LAST) begin
            state_q <= STABLE_HI;
            level_q <= 1'b1;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        WAIT_LO: begin
          if (btn_s) begin
            state_q <= STABLE_HI;
            cnt_q   <= '0;
          end else if (cnt_q == CNT_LAST) begin
            state_q <= STABLE_LO;
            level_q <= 1'b0;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_q <= STABLE_LO;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign level = level_q;
  assign rise  = level_q & ~level_dly_q;

endmodule

// File: rtl/io_input_ctrl.sv
// rtl/io_input_ctrl.sv - button/switch front end latching a switch word per debounced press
// IO_IN_OVERWRITE_EN: a press while a word is pending replaces it instead of keeping the oldest
module io_input_ctrl
  import io_pkg::*;
#(
  parameter int  SW_W      = 16,
  parameter int  DB_CYCLES = DB_CYCLES_DEF,
  localparam int CNT_W     = $clog2(DB_CYCLES + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 btn_in,
  input  logic [SW_W-1:0]      sw_in,
  input  logic                 ack,
  output logic [IO_DATA_W-1:0] data_input,
  output logic                 is_ready_1,
  output logic                 overrun
);

  logic                 btn_level;
  logic                 press;
  logic [SW_W-1:0]      sw_s1_q;
  logic [SW_W-1:0]      sw_s_q;
  logic [IO_DATA_W-1:0] sw_word;
  cap_state_e           state_q;
  logic [IO_DATA_W-1:0] data_q;
  logic                 ready_q;
  logic                 overrun_q;

  io_debounce #(
    .DB_CYCLES(DB_CYCLES),
    .CNT_W    (CNT_W)
  ) u_db (
    .clk  (clk),
    .rst  (rst),
    .raw  (btn_in),
    .level(btn_level),
    .rise (press)
  );

  assign sw_word = IO_DATA_W'(sw_s_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sw_s1_q   <= '0;
      sw_s_q    <= '0;
      state_q   <= IDLE;
      data_q    <= '0;
      ready_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      sw_s1_q <= sw_in;
      sw_s_q  <= sw_s1_q;
      case (state_q)
        IDLE: if (press) begin
          data_q  <= sw_word;
          ready_q <= 1'b1;
          state_q <= FULL;
        end
        FULL: begin
          // ack is consumed before a coincident press, so that press is a fresh capture
          if (ack && press) begin
            data_q    <= sw_word;
            overrun_q <= 1'b0;
          end else if (ack) begin
            ready_q   <= 1'b0;
            overrun_q <= 1'b0;
            state_q   <= IDLE;
          end else if (press) begin
            overrun_q <= 1'b1;
`ifdef IO_IN_OVERWRITE_EN
            data_q    <= sw_word;
`else
            data_q    <= data_q;
`endif
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign data_input = data_q;
  assign is_ready_1 = ready_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_io_input_ctrl.sv
// tb/tb_io_input_ctrl.sv - self-checking bench for io_input_ctrl with DB_CYCLES=4, SW_W=16
module tb_io_input_ctrl;

  localparam int DB = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        btn_in = 1'b0;
  logic [15:0] sw_in = 16'h0;
  logic        ack = 1'b0;
  logic [31:0] data_input;
  logic        is_ready_1;
  logic        overrun;

  int tests = 0;
  int fails = 0;
  int rises = 0;
  logic rdy_prev = 1'b0;

  io_input_ctrl #(
    .SW_W     (16),
    .DB_CYCLES(DB)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_in    (btn_in),
    .sw_in     (sw_in),
    .ack       (ack),
    .data_input(data_input),
    .is_ready_1(is_ready_1),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Model: debounced level follows the synchronized button once it has held a new value
  // for DB consecutive samples; captures follow the handshake rules directly.
  logic        m_b1 = 0, m_b2 = 0, m_last = 0, m_lvl = 0, m_lvl_p = 0;
  int          m_run = 0;
  logic [15:0] m_sw1 = 0, m_sw2 = 0;
  logic        m_rdy = 0, m_ov = 0;
  logic [31:0] m_data = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_b1 = 0; m_b2 = 0; m_last = 0; m_lvl = 0; m_lvl_p = 0; m_run = 0;
      m_sw1 = 0; m_sw2 = 0; m_rdy = 0; m_ov = 0; m_data = 0;
    end else begin
      logic pressed;
      pressed = m_lvl && !m_lvl_p;
      if (m_rdy && ack) begin
        m_rdy = 0;
        m_ov  = 0;
      end
      if (pressed) begin
        if (m_rdy) begin
          m_ov = 1;
`ifdef IO_IN_OVERWRITE_EN
          m_data = {16'h0, m_sw2};
`endif
        end else begin
          m_data = {16'h0, m_sw2};
          m_rdy  = 1;
        end
      end
      m_lvl_p = m_lvl;
      if (m_b2 == m_last) m_run++;
      else m_run = 1;
      m_last = m_b2;
      if (m_b2 != m_lvl && m_run >= DB) m_lvl = m_b2;
      m_b2  = m_b1;
      m_b1  = btn_in;
      m_sw2 = m_sw1;
      m_sw1 = sw_in;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      check("model_data", data_input, m_data);
      check("model_ready", {31'h0, is_ready_1}, {31'h0, m_rdy});
      check("model_overrun", {31'h0, overrun}, {31'h0, m_ov});
      if (is_ready_1 && !rdy_prev) rises++;
      rdy_prev = is_ready_1;
    end else begin
      rdy_prev = 1'b0;
    end
  end

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press_measure(input logic [15:0] sw, output int lat);
    @(negedge clk);
    sw_in  = sw;
    btn_in = 1'b1;
    lat = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      lat++;
      if (is_ready_1) break;
    end
  endtask

  task automatic ack_pulse();
    @(negedge clk);
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
  endtask

  task automatic press_release(input logic [15:0] sw);
    @(negedge clk);
    sw_in  = sw;
    btn_in = 1'b1;
    wait_neg(9);
    btn_in = 1'b0;
    wait_neg(10);
  endtask

  initial begin
    int lat;
    int r0;
    #1 rst = 1'b1;
    #20;
    check("reset_data", data_input, 32'h0);
    check("reset_ready", {31'h0, is_ready_1}, 32'h0);
    check("reset_overrun", {31'h0, overrun}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    wait_neg(3);

    // clean press
    press_measure(16'hA5A5, lat);
    check("clean_latency", lat, 7);
    check("clean_data", data_input, 32'h0000A5A5);
    ack_pulse();
    check("ack_clears_ready", {31'h0, is_ready_1}, 32'h0);
    check("ack_keeps_data", data_input, 32'h0000A5A5);
    @(negedge clk);
    btn_in = 1'b0;
    wait_neg(12);

    // bounce rejection, then a clean press proves the debouncer is back in its low state
    r0 = rises;
    btn_in = 1'b1; wait_neg(2);
    btn_in = 1'b0; wait_neg(2);
    btn_in = 1'b1; wait_neg(2);
    btn_in = 1'b0; wait_neg(12);
    check("bounce_no_capture", rises - r0, 0);
    press_measure(16'h1234, lat);
    check("bounce_recover_latency", lat, 7);
    check("bounce_recover_data", data_input, 32'h00001234);
    ack_pulse();
    btn_in = 1'b0;
    wait_neg(12);

    // overrun
    press_release(16'h0001);
    press_release(16'h0002);
    check("overrun_set", {31'h0, overrun}, 32'h1);
    check("overrun_ready", {31'h0, is_ready_1}, 32'h1);
`ifdef IO_IN_OVERWRITE_EN
    check("overrun_data", data_input, 32'h00000002);
`else
    check("overrun_data", data_input, 32'h00000001);
`endif
    ack_pulse();
    check("overrun_ack_ov", {31'h0, overrun}, 32'h0);
    check("overrun_ack_ready", {31'h0, is_ready_1}, 32'h0);

    // simultaneous ack and press with an overrun pending
    press_release(16'h0003);
    press_release(16'h0004);
    check("simul_pre_overrun", {31'h0, overrun}, 32'h1);
    @(negedge clk);
    sw_in  = 16'h00FF;
    btn_in = 1'b1;
    wait_neg(6);
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    check("simul_ready", {31'h0, is_ready_1}, 32'h1);
    check("simul_data", data_input, 32'h000000FF);
    check("simul_overrun", {31'h0, overrun}, 32'h0);
    ack_pulse();
    btn_in = 1'b0;
    wait_neg(12);

    // long hold: one capture, nothing on release
    r0 = rises;
    @(negedge clk);
    sw_in  = 16'hBEEF;
    btn_in = 1'b1;
    wait_neg(10);
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    wait_neg(90);
    btn_in = 1'b0;
    wait_neg(20);
    check("hold_one_capture", rises - r0, 1);
    check("hold_no_ready", {31'h0, is_ready_1}, 32'h0);
    check("hold_data", data_input, 32'h0000BEEF);

    // reset with a word pending, away from any clock edge
    press_release(16'h5555);
    check("pre_reset_ready", {31'h0, is_ready_1}, 32'h1);
    @(negedge clk);
    btn_in = 1'b1;
    #2 rst = 1'b1;
    #1;
    check("async_reset_data", data_input, 32'h0);
    check("async_reset_ready", {31'h0, is_ready_1}, 32'h0);
    check("async_reset_overrun", {31'h0, overrun}, 32'h0);
    btn_in = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    wait_neg(15);
    check("post_reset_ready", {31'h0, is_ready_1}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
